// File: rtl/shf_pkg.sv
// Shared definitions for the LC-3b SHF datapath: sequencer states, operand
// width and the ir[5:4] shift-mode encodings.
package shf_pkg;

   localparam int SHF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      LSHF  = 2'b00,
      RSHFL = 2'b01,
      RSHFA = 2'b11
   } shf_mode_t;

   // Decodes ir[5:4] into the arith select used by the right shifter.
   function automatic logic mode_is_arith(input logic [1:0] mode);
      logic res;
      case (mode)
         RSHFA:   res = 1'b1;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/rshf_iter_if.sv
// Request/response bundle between the microsequencer and the iterative
// right shifter.
interface rshf_iter_if
   import shf_pkg::*;
#(
   parameter int WIDTH = SHF_WIDTH,
   parameter int CNT_W = 4
);

   logic             start;
   logic [WIDTH-1:0] in;
   logic [CNT_W-1:0] amount;
   logic             arith;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;

   modport master (
      output start, in, amount, arith,
      input  busy, done, out
   );

   modport slave (
      input  start, in, amount, arith,
      output busy, done, out
   );

endinterface

// File: rtl/rshf1.sv
// Single-bit right shift; the vacated MSB takes the sign bit when arith is set.
module rshf1 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] in,
   input  logic             arith,
   output logic [WIDTH-1:0] out
);

   // Shift down one place, then refill the top bit.
   always_comb begin
      out            = in >> 1;
      out[WIDTH-1]   = arith & in[WIDTH-1];
   end

endmodule

// File: rtl/rshf_iter.sv
// Iterative right shifter (RSHFL/RSHFA): one bit per clock, with a
// one-cycle done pulse. Requires 2**CNT_W <= WIDTH.
module rshf_iter
   import shf_pkg::*;
#(
   parameter int WIDTH = SHF_WIDTH,
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   rshf_iter_if.slave   bus
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   state_t           state_r;
   state_t           next_state_s;
   logic [WIDTH-1:0] data_r;
   logic [CNT_W-1:0] count_r;
   logic             mode_r;
   logic [WIDTH-1:0] out_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] shifted_s;

   rshf1 #(.WIDTH(WIDTH)) u_rshf1 (
      .in    (data_r),
      .arith (mode_r),
      .out   (shifted_s)
   );

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               next_state_s = (bus.amount != CNT_ZERO) ? SHIFT : DONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         SHIFT: begin
            if (count_r == CNT_ONE) begin
               next_state_s = DONE;
            end else begin
               next_state_s = SHIFT;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register plus registered busy/done decodes of the upcoming state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         busy_r  <= (next_state_s != IDLE);
         done_r  <= (next_state_s == DONE);
      end
   end

   // Operand capture, per-cycle shift and result write-back.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_r  <= {WIDTH{1'b0}};
         count_r <= CNT_ZERO;
         mode_r  <= 1'b0;
         out_r   <= {WIDTH{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  data_r  <= bus.in;
                  count_r <= bus.amount;
                  mode_r  <= bus.arith;
                  if (bus.amount == CNT_ZERO) begin
                     out_r <= bus.in;
                  end
               end
            end
            SHIFT: begin
               data_r  <= shifted_s;
               count_r <= count_r - CNT_ONE;
               if (count_r == CNT_ONE) begin
                  out_r <= shifted_s;
               end
            end
            DONE: begin
               data_r <= data_r;
            end
            default: begin
               data_r  <= {WIDTH{1'b0}};
               count_r <= CNT_ZERO;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.out  = out_r;

endmodule

// File: tb/tb_rshf_iter.sv
// Directed bench for rshf_iter: expected results are queued at start and
// checked against out and the cycle number whenever done pulses.
module tb_rshf_iter;
   import shf_pkg::*;

   typedef struct {
      logic [15:0] val;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   exp_t sb[$];

   rshf_iter_if #(.WIDTH(16), .CNT_W(4)) bus ();

   rshf_iter #(.WIDTH(16), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Scoreboard: every done pulse must match the oldest queued job.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", {16'd0, bus.out}, {16'd0, e.val});
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive start for one cycle; queue the expectation when acceptance is expected.
   task automatic start_job(input logic [15:0] d, input logic [3:0] a, input logic ar,
                            input logic [15:0] e, input bit push);
      exp_t x;
      bus.start  = 1'b1;
      bus.in     = d;
      bus.amount = a;
      bus.arith  = ar;
      if (push) begin
         x.val = e;
         x.cyc = cyc + int'(a) + 1;
         sb.push_back(x);
      end
      tick();
      bus.start  = 1'b0;
      bus.in     = 16'hA5A5;
      bus.amount = 4'hF;
      bus.arith  = ~ar;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (bus.busy === 1'b0) break;
         tick();
      end
      check("idle_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic wait_until(input int target);
      for (int i = 0; i < 40; i++) begin
         if (cyc >= target) break;
         tick();
      end
      check("cycle_reached", cyc, target);
   endtask

   initial begin
      int c0;
      bus.start  = 1'b0;
      bus.in     = 16'h0000;
      bus.amount = 4'h0;
      bus.arith  = 1'b0;

      // 1: reset, then 0x8001 >> 1 logical
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("rst_out", {16'd0, bus.out}, 32'h0000);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      c0 = cyc;
      start_job(16'h8001, 4'd1, 1'b0, 16'h4000, 1'b1);
      check("t1_busy_c1", {31'd0, bus.busy}, 32'd1);
      tick();
      check("t1_busy_c2", {31'd0, bus.busy}, 32'd1);
      tick();
      check("t1_busy_c3", {31'd0, bus.busy}, 32'd0);
      check("t1_hold", {16'd0, bus.out}, 32'h4000);

      // 2: full-range shifts, arithmetic then logical
      start_job(16'h8000, 4'd15, 1'b1, 16'hFFFF, 1'b1);
      wait_idle();
      tick();
      start_job(16'h8000, 4'd15, 1'b0, 16'h0001, 1'b1);
      wait_idle();
      tick();

      // 3: zero shift amount
      start_job(16'h1234, 4'd0, 1'b0, 16'h1234, 1'b1);
      check("t3_busy_c1", {31'd0, bus.busy}, 32'd1);
      tick();
      check("t3_busy_c2", {31'd0, bus.busy}, 32'd0);
      tick();

      // 4: start while busy is ignored; next start after done accepted
      c0 = cyc;
      start_job(16'hF0F0, 4'd4, 1'b0, 16'h0F0F, 1'b1);
      start_job(16'hFFFF, 4'd1, 1'b0, 16'h0000, 1'b0);
      wait_until(c0 + 6);
      check("t4_idle_c6", {31'd0, bus.busy}, 32'd0);
      check("t4_out", {16'd0, bus.out}, 32'h0F0F);
      start_job(16'h8421, 4'd2, 1'b1, 16'hE108, 1'b1);
      check("t4_accept", {31'd0, bus.busy}, 32'd1);
      wait_idle();
      tick();

      // 5: reset aborts a job in progress
      c0 = cyc;
      start_job(16'hC000, 4'd8, 1'b1, 16'h0000, 1'b0);
      wait_until(c0 + 3);
      rst_n = 1'b0;
      tick();
      check("t5_busy", {31'd0, bus.busy}, 32'd0);
      check("t5_out", {16'd0, bus.out}, 32'h0000);
      check("t5_done", {31'd0, bus.done}, 32'd0);
      rst_n = 1'b1;
      tick();
      start_job(16'h00F0, 4'd4, 1'b0, 16'h000F, 1'b1);
      wait_idle();
      tick();

      // 6: back-to-back jobs
      c0 = cyc;
      start_job(16'h0100, 4'd8, 1'b0, 16'h0001, 1'b1);
      wait_until(c0 + 10);
      start_job(16'h7FFF, 4'd3, 1'b0, 16'h0FFF, 1'b1);
      wait_idle();
      tick();
      tick();

      check("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
